// File: rtl/sync_regen_pkg.sv
// Shared types and default 81 MHz timing for the composite-sync regenerator.
package sync_regen_pkg;

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    FLYWHEEL = 2'd3
  } state_e;

  localparam int TIMER_W = 16;

  localparam int LINE_625_DEF     = 5184;
  localparam int LINE_525_DEF     = 5148;
  localparam int LINE_TOL_DEF     = 200;
  localparam int LOCK_COUNT_DEF   = 4;
  localparam int MISS_LIMIT_DEF   = 8;
  localparam int HSYNC_WIDTH_DEF  = 381;
  localparam int VWIN_START_DEF   = 648;
  localparam int VWIN_END_DEF     = 4212;
  localparam int FIELD_THRESH_DEF = 1620;
  localparam int LINE_W_DEF       = 10;

  function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
    return (&v) ? v : v + TIMER_W'(1);
  endfunction

endpackage

// File: rtl/csync_sync_edge.sv
// Two-flop synchroniser for the raw csync pin plus registered single-cycle edge pulses.
module csync_sync_edge (
  input  logic clk_i,
  input  logic n_reset_i,
  input  logic csync_i,
  output logic fall_o,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q;
  logic fall_q, rise_q;

  // Synchroniser resets to the idle (high) level so release never fakes an edge.
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= csync_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      fall_q <= prev_q & ~sync_q;
      rise_q <= ~prev_q & sync_q;
    end
  end

  assign fall_o = fall_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/sync_regenerator_flywheel.sv
// Recovers hsync/vsync/field/line number from composite sync, with a lock FSM and
// flywheel that substitutes synthetic hsyncs for missing pulses.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   SEARCH   | no timing reference; first falling edge starts acquisition
//   ACQUIRE  | counting consecutive in-window falling edges toward lock
//   LOCKED   | tracking; falling or rising edges accepted in the window
//   FLYWHEEL | edges missing; synthetic hsync every period until limit
module sync_regenerator_flywheel
  import sync_regen_pkg::*;
#(
  parameter int LINE_625     = LINE_625_DEF,
  parameter int LINE_525     = LINE_525_DEF,
  parameter int LINE_TOL     = LINE_TOL_DEF,
  parameter int LOCK_COUNT   = LOCK_COUNT_DEF,
  parameter int MISS_LIMIT   = MISS_LIMIT_DEF,
  parameter int HSYNC_WIDTH  = HSYNC_WIDTH_DEF,
  parameter int VWIN_START   = VWIN_START_DEF,
  parameter int VWIN_END     = VWIN_END_DEF,
  parameter int FIELD_THRESH = FIELD_THRESH_DEF,
  parameter int LINE_W       = LINE_W_DEF
) (
  input  logic              clk_i,
  input  logic              n_reset_i,
  input  logic              csync_i,
  input  logic              is525_i,
  output logic              hsync_o,
  output logic              hsync_wide_o,
  output logic              vsync_o,
  output logic              is_field_odd_o,
  output logic [LINE_W-1:0] line_number_o,
  output logic              locked_o,
  output logic              flywheel_active_o
);

  localparam int WIDE_W = $clog2(HSYNC_WIDTH + 1);

  localparam logic [TIMER_W-1:0] P625_T = TIMER_W'(LINE_625);
  localparam logic [TIMER_W-1:0] P525_T = TIMER_W'(LINE_525);
  localparam logic [TIMER_W-1:0] TOL_T  = TIMER_W'(LINE_TOL);
  localparam logic [TIMER_W-1:0] VS_T   = TIMER_W'(VWIN_START);
  localparam logic [TIMER_W-1:0] VE_T   = TIMER_W'(VWIN_END);
  localparam logic [TIMER_W-1:0] FT_T   = TIMER_W'(FIELD_THRESH);
  localparam logic [7:0]         LOCK_C = 8'(LOCK_COUNT);
  localparam logic [7:0]         MISS_C = 8'(MISS_LIMIT);
  localparam logic [WIDE_W-1:0]  WIDE_T = WIDE_W'(HSYNC_WIDTH);

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  lt_q, lt_d;
  logic [7:0]          good_q, good_d;
  logic [7:0]          miss_q, miss_d;
  logic                period_sel_q, period_sel_d;
  logic                hs_q, hs_d;
  logic                vs_q, vs_d;
  logic                armed_q, armed_d;
  logic                odd_q, odd_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [WIDE_W-1:0]   wide_q, wide_d;

  logic                fall, rise;
  logic                synthetic;
  logic                in_win, accept_fall, accept_any, timeout, is_locked;
  logic [TIMER_W-1:0]  period, win_lo, win_hi;

  csync_sync_edge u_edge (
    .clk_i     (clk_i),
    .n_reset_i (n_reset_i),
    .csync_i   (csync_i),
    .fall_o    (fall),
    .rise_o    (rise)
  );

  assign period      = period_sel_q ? P525_T : P625_T;
  assign win_lo      = period - TOL_T;
  assign win_hi      = period + TOL_T;
  assign in_win      = (lt_q >= win_lo) && (lt_q <= win_hi);
  assign accept_fall = fall && in_win;
  assign accept_any  = (fall || rise) && in_win;
  // The timer holds 0 (or LINE_TOL) in the hsync cycle itself, so firing one count
  // early puts the synthetic pulse exactly P+LINE_TOL after the last real one.
  assign timeout     = (lt_q >= win_hi - TIMER_W'(1));
  assign is_locked   = (state_q == LOCKED) || (state_q == FLYWHEEL);

  always_comb begin
    state_d      = state_q;
    good_d       = good_q;
    miss_d       = miss_q;
    period_sel_d = period_sel_q;
    hs_d         = 1'b0;
    synthetic    = 1'b0;

    unique case (state_q)
      SEARCH: begin
        if (fall) begin
          hs_d         = 1'b1;
          good_d       = 8'd1;
          period_sel_d = is525_i;
          state_d      = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (accept_fall) begin
          hs_d   = 1'b1;
          good_d = good_q + 8'd1;
          if (good_q + 8'd1 >= LOCK_C) state_d = LOCKED;
        end else if (lt_q > win_hi) begin
          good_d  = 8'd0;
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (accept_any) begin
          hs_d = 1'b1;
        end else if (timeout) begin
          hs_d      = 1'b1;
          synthetic = 1'b1;
          miss_d    = 8'd1;
          state_d   = FLYWHEEL;
        end
      end
      FLYWHEEL: begin
        if (miss_q >= MISS_C) begin
          miss_d  = 8'd0;
          good_d  = 8'd0;
          state_d = SEARCH;
        end else if (accept_any) begin
          hs_d    = 1'b1;
          miss_d  = 8'd0;
          state_d = LOCKED;
        end else if (timeout) begin
          hs_d      = 1'b1;
          synthetic = 1'b1;
          miss_d    = miss_q + 8'd1;
        end
      end
      default: state_d = SEARCH;
    endcase

    if (hs_d) lt_d = synthetic ? TOL_T : '0;
    else      lt_d = sat_inc(lt_q);

    vs_d = is_locked && fall && armed_q && (lt_q >= VS_T) && (lt_q < VE_T);

    armed_d = armed_q;
    if ((state_q == SEARCH) || (state_d == SEARCH)) armed_d = 1'b0;
    else if (vs_d)                                  armed_d = 1'b0;
    else if (lt_q >= VE_T)                          armed_d = 1'b1;

    odd_d = vs_d ? (lt_q <= FT_T) : odd_q;

    line_d = line_q;
    if (vs_d)                  line_d = '0;
    else if (hs_d && !(&line_q)) line_d = line_q + LINE_W'(1);

    wide_d = wide_q;
    if (hs_d)              wide_d = WIDE_T;
    else if (wide_q != '0) wide_d = wide_q - WIDE_W'(1);
  end

  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q      <= SEARCH;
      lt_q         <= '1;
      good_q       <= '0;
      miss_q       <= '0;
      period_sel_q <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      armed_q      <= 1'b0;
      odd_q        <= 1'b0;
      line_q       <= '0;
      wide_q       <= '0;
    end else begin
      state_q      <= state_d;
      lt_q         <= lt_d;
      good_q       <= good_d;
      miss_q       <= miss_d;
      period_sel_q <= period_sel_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      armed_q      <= armed_d;
      odd_q        <= odd_d;
      line_q       <= line_d;
      wide_q       <= wide_d;
    end
  end

  assign hsync_o           = hs_q;
  assign hsync_wide_o      = (wide_q != '0);
  assign vsync_o           = vs_q;
  assign is_field_odd_o    = odd_q;
  assign line_number_o     = line_q;
  assign locked_o          = is_locked;
  assign flywheel_active_o = (state_q == FLYWHEEL);

endmodule

// File: doc/sync_regenerator_flywheel.md
Name: sync_regenerator_flywheel

Overview:
Parametrised successor to the PAL 576i sync regenerator. Recovers hsync, vsync, field parity and line number from composite sync for 625- or 525-line sources, selectable at runtime. Adds a lock state machine with a flywheel, so missing or corrupted sync pulses are replaced by synthetic hsync pulses. It also outputs a line counter and a stretched hsync. Sits between the csync input pin and the video timing and overlay logic, clocked by the 81 MHz system clock.

Parameters:
LINE_625, 5184, nominal line period in clk cycles for 625-line mode (64 us at 81 MHz)
LINE_525, 5148, nominal line period for 525-line mode (63.556 us)
LINE_TOL, 200, acceptance half-window around the nominal period, in cycles
LOCK_COUNT, 4, consecutive in-window hsyncs needed to declare lock
MISS_LIMIT, 8, consecutive synthetic hsyncs after which lock is dropped
HSYNC_WIDTH, 381, hsyncWide pulse length (4.7 us)
VWIN_START, 648, start of the vsync detection window after hsync (8 us)
VWIN_END, 4212, end of the vsync detection window, exclusive (52 us)
FIELD_THRESH, 1620, vsync-to-hsync offset at or below which the field is odd (20 us)
LINE_W, 10, lineNumber width

Ports:
clk  in  1  system clock, 81 MHz
nReset  in  1  asynchronous active-low reset
csync  in  1  raw composite sync, active low, asynchronous to clk
is525  in  1  0 = 625-line timing, 1 = 525-line timing; sampled only in SEARCH
hsync  out  1  single-cycle pulse at each line start, real or synthetic
hsyncWide  out  1  HSYNC_WIDTH-cycle pulse starting with hsync
vsync  out  1  single-cycle pulse at field sync start
isFieldOdd  out  1  1 = odd field, 0 = even field
lineNumber  out  LINE_W  hsyncs since last vsync, saturating at all-ones
locked  out  1  1 in LOCKED or FLYWHEEL
flywheelActive  out  1  1 in FLYWHEEL

Behaviour:
- Reset (async assert, sync deassert): all outputs 0; state SEARCH; counters 0; lineTimer = 0xFFFF.
- Input path: csync passes through a 2-FF synchroniser, then a registered edge detector. Latency from a csync pin transition to hsync is exactly 4 clk.
- lineTimer: 16 bit. Increments every cycle and saturates at 0xFFFF. Reset to 0 on every hsync except synthetic hsyncs (see FLYWHEEL).
- P = LINE_525 if periodSel else LINE_625, where periodSel is latched from is525 on leaving SEARCH. Acceptance window W = [P-LINE_TOL, P+LINE_TOL].
- SEARCH: the first falling edge emits hsync, sets goodCount = 1 and moves to ACQUIRE.
- ACQUIRE: only falling edges count.
  - Falling edge with lineTimer in W: emit hsync and increment goodCount. When goodCount reaches LOCK_COUNT, move to LOCKED.
  - Falling edge outside W: ignored, and lineTimer is not reset.
  - lineTimer > P+LINE_TOL: return to SEARCH with goodCount = 0.
- LOCKED: falling or rising edges are accepted in W. This is how serration and broad pulses are tracked during vsync. Edges outside W are ignored.
  - If lineTimer reaches P+LINE_TOL with no accepted edge: emit a synthetic hsync, set lineTimer = LINE_TOL, set missCount = 1 and move to FLYWHEEL.
- FLYWHEEL: same acceptance rule as LOCKED.
  - Accepted edge: emit hsync, clear missCount and return to LOCKED.
  - lineTimer reaches P+LINE_TOL: emit a synthetic hsync, set lineTimer = LINE_TOL and increment missCount.
  - missCount == MISS_LIMIT: go to SEARCH, clear locked, emit no further hsync.
  - Synthetic hsyncs therefore recur every P cycles.
- Simultaneous edge and timeout in the same cycle: the edge wins and is treated as accepted.
- hsyncWide: starts on the cycle hsync is asserted and lasts HSYNC_WIDTH cycles. A new hsync during the pulse restarts it.
- vsync is generated only when locked = 1.
  - Asserted for one cycle when a synchronised csync falling edge occurs with lineTimer in [VWIN_START, VWIN_END) and vsyncArmed = 1.
  - The pulse clears vsyncArmed. vsyncArmed is set again when lineTimer ≥ VWIN_END.
  - At most one vsync per line.
- Field parity: on the vsync cycle, isFieldOdd <= (lineTimer <= FIELD_THRESH).
- lineNumber:
  - Set to 0 on the vsync cycle; vsync takes priority over a coincident hsync, which cannot occur given the window.
  - Otherwise increments on each hsync and saturates at all-ones.
- Dropping to SEARCH clears vsyncArmed and flywheelActive. isFieldOdd and lineNumber hold their values.

Decomposition:
- Package sync_regen_pkg:
  - state enum {SEARCH, ACQUIRE, LOCKED, FLYWHEEL};
  - default 81 MHz timing constants for 625- and 525-line modes;
  - TIMER_W = 16.
- One sub-module, csync_sync_edge: 2-FF synchroniser plus registered falling/rising single-cycle pulses.

Test Plan:
- Clean 625-line csync with 64 us lines: hsync on lines 1–4 with fixed 4-clk latency; locked = 1 after the 4th pulse; hsync spacing 5184 clk; hsyncWide high for 381 clk.
- Locked, then 3 csync pulses removed: first synthetic hsync 5384 clk after the last real one, then two more 5184 clk apart; flywheelActive = 1; returns to LOCKED with flywheelActive = 0 on the next real edge; lineNumber keeps counting.
- Locked, then csync held high for 10 lines: SEARCH entered after the 8th synthetic hsync; locked = 0; no hsync until csync resumes.
- Odd-field vsync (broad pulse at line start): vsync 1 pulse; isFieldOdd = 1; lineNumber = 0 then increments. Even field (broad pulse at the 32 us half-line, lineTimer ≈ 2592): isFieldOdd = 0.
- ACQUIRE with a spurious falling edge at lineTimer 2000: ignored, with no hsync and no timer reset. With is525 = 1, lock occurs at a 5148-clk period, and a 5184 ± 0 source also locks within tolerance.
- nReset pulled low mid-LOCKED: all outputs 0 immediately, without a clock edge; after release, relock takes 4 lines.
